// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding word per request, held in HOLD until consumed.
// Optional macro FETCH_MISALIGN_CHECK_EN adds misalign_err and word-aligns redirect targets.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_imem_req;
  logic [31:0] w_redirect_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        r_misalign_err;
  logic        w_misaligned;

  assign w_misaligned  = (redirect_target[1:0] != 2'b00);
  assign w_redirect_pc = {redirect_target[31:2], 2'b00};
  assign misalign_err  = r_misalign_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= redirect_valid && w_misaligned;
    end
  end
`else
  assign w_redirect_pc = redirect_target;
`endif

  // Redirect overrides every transition, including an ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else if (redirect_valid) begin
      r_state       <= REQ;
      r_pc          <= w_redirect_pc;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= REQ;
          r_imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_pc          <= r_pc + 32'd4;
            r_state       <= HOLD;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            r_state       <= REQ;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_instr_valid <= 1'b0;
          r_imem_req    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign opcode      = r_instr[6:0];
  assign pc_plus4    = r_instr_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; set FETCH_MISALIGN_CHECK_EN to cover misalign_err.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checkCount = 0;
  int passCount  = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_err    (misalign_err),
`endif
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .opcode          (opcode),
    .pc_plus4        (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge; inputs change here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic ack, input logic [31:0] rdata,
                               input logic rv, input logic [31:0] tgt, input logic st);
    rst             = r;
    imem_ack        = ack;
    imem_rdata      = rdata;
    redirect_valid  = rv;
    redirect_target = tgt;
    stall           = st;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();

    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_req",   32'(imem_req),    32'd0);
    checkOutput("rst_addr",  imem_addr,        32'h0);
    checkOutput("rst_instr", instr,            32'h0000_0013);
    checkOutput("rst_ipc",   instr_pc,         32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("rst_mis",   32'(misalign_err), 32'd0);
`endif

    // Cycle 1 after release is IDLE, cycle 2 REQ with ack, cycle 3 instr_valid.
    applyStimulus(1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
    checkOutput("c1_req",   32'(imem_req),    32'd0);
    checkOutput("c1_valid", 32'(instr_valid), 32'd0);
    tick();
    checkOutput("c2_req",   32'(imem_req),    32'd1);
    checkOutput("c2_addr",  imem_addr,        32'h0);
    checkOutput("c2_valid", 32'(instr_valid), 32'd0);
    tick();
    checkOutput("c3_valid",  32'(instr_valid), 32'd1);
    checkOutput("c3_instr",  instr,            32'h0050_0093);
    checkOutput("c3_ipc",    instr_pc,         32'h0);
    checkOutput("c3_opcode", 32'(opcode),      32'h13);
    checkOutput("c3_plus4",  pc_plus4,         32'h4);
    checkOutput("c3_req",    32'(imem_req),    32'd0);

    // Stall in HOLD for four cycles.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("stall%0d_valid", i), 32'(instr_valid), 32'd1);
      checkOutput($sformatf("stall%0d_instr", i), instr,            32'h0050_0093);
      checkOutput($sformatf("stall%0d_ipc", i),   instr_pc,         32'h0);
      checkOutput($sformatf("stall%0d_req", i),   32'(imem_req),    32'd0);
    end
    stall = 1'b0;
    tick();
    checkOutput("rel_valid", 32'(instr_valid), 32'd0);
    checkOutput("rel_req",   32'(imem_req),    32'd1);
    checkOutput("rel_addr",  imem_addr,        32'h4);

    // Stall while in REQ must not block the fetch.
    applyStimulus(1'b0, 1'b1, 32'h00a0_0113, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("reqst_valid", 32'(instr_valid), 32'd1);
    checkOutput("reqst_instr", instr,            32'h00a0_0113);
    checkOutput("reqst_ipc",   instr_pc,         32'h4);
    checkOutput("reqst_addr",  imem_addr,        32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("req2_req", 32'(imem_req), 32'd1);

    // Redirect together with ack: the word is dropped.
    applyStimulus(1'b0, 1'b1, 32'hdead_beef, 1'b1, 32'h0000_0100, 1'b0);
    tick();
    checkOutput("rdack_valid", 32'(instr_valid), 32'd0);
    checkOutput("rdack_addr",  imem_addr,        32'h100);
    checkOutput("rdack_req",   32'(imem_req),    32'd1);
    checkOutput("rdack_instr", instr,            32'h00a0_0113);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("rdwait_valid", 32'(instr_valid), 32'd0);

    applyStimulus(1'b0, 1'b1, 32'h0000_006f, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("jal_ipc",    instr_pc,    32'h100);
    checkOutput("jal_opcode", 32'(opcode), 32'h6f);
    checkOutput("jal_plus4",  pc_plus4,    32'h104);

    // Redirect out of HOLD to the top word, then wrap.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    checkOutput("rdhold_valid", 32'(instr_valid), 32'd0);
    checkOutput("rdhold_addr",  imem_addr,        32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_ipc",   instr_pc,  32'hFFFF_FFFC);
    checkOutput("wrap_plus4", pc_plus4,  32'h0);
    checkOutput("wrap_addr",  imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_req", 32'(imem_req), 32'd1);

    // Reset mid-REQ beats a simultaneous redirect and ack.
    applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0200, 1'b0);
    tick();
    checkOutput("rstreq_req",   32'(imem_req),    32'd0);
    checkOutput("rstreq_valid", 32'(instr_valid), 32'd0);
    checkOutput("rstreq_addr",  imem_addr,        32'h0);
    checkOutput("rstreq_instr", instr,            32'h0000_0013);
    checkOutput("rstreq_ipc",   instr_pc,         32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("postrst_req", 32'(imem_req), 32'd0);
    tick();
    checkOutput("postrst_req2",  32'(imem_req), 32'd1);
    checkOutput("postrst_addr2", imem_addr,     32'h0);

    // Misaligned redirect target.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b0);
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("mis_addr", imem_addr,          32'h100);
    checkOutput("mis_err",  32'(misalign_err),  32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("mis_err_clr", 32'(misalign_err), 32'd0);
`else
    checkOutput("mis_addr", imem_addr, 32'h102);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
`endif
    checkOutput("mis_req", 32'(imem_req), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  byte address of the requested word; always equals the PC register.
REQ-006 SHALL have port imem_ack  input  1  memory has read data valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, sampled only when imem_ack=1.
REQ-008 SHALL have port redirect_valid  input  1  taken branch or jal, one-cycle pulse.
REQ-009 SHALL have port redirect_target  input  32  new PC on redirect.
REQ-010 SHALL have port stall  input  1  downstream not ready to consume instr.
REQ-011 SHALL have port instr_valid  output  1  instr, instr_pc and opcode are valid.
REQ-012 SHALL have port instr  output  32  fetched instruction word.
REQ-013 SHALL have port instr_pc  output  32  address of instr.
REQ-014 SHALL have port opcode  output  7  instr[6:0], feeding the main decoder.
REQ-015 SHALL have port pc_plus4  output  32  instr_pc + 4, for the jal link value.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, REQ, HOLD.
REQ-017 IDLE: imem_req=0, instr_valid=0; SHALL go to REQ on the next cycle unconditionally.
REQ-018 REQ: imem_req=1; on imem_ack=1 SHALL register instr=imem_rdata and instr_pc=pc, set pc<=pc+4, and go to HOLD.
REQ-019 Latency: instr_valid SHALL assert in the cycle after the imem_ack cycle.
REQ-020 HOLD: instr_valid=1 and imem_req=0; with stall=1, instr, instr_pc and opcode SHALL hold; with stall=0, SHALL go to REQ next cycle, and instr_valid SHALL drop.
REQ-021 stall SHALL have no effect in IDLE or REQ.
REQ-022 redirect_valid=1 in any state SHALL load pc<=redirect_target, clear instr_valid next cycle, and enter REQ, overriding every other transition.
REQ-023 redirect_valid and imem_ack in the same cycle: imem_rdata SHALL be discarded and no instr_valid issued for it.
REQ-024 An imem_addr change while imem_req stays high SHALL be legal; the memory holds no outstanding state.
REQ-025 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-026 opcode and pc_plus4 SHALL be combinational from instr and instr_pc.

Reset
REQ-027 rst=1 SHALL have priority over redirect_valid, imem_ack and stall.
REQ-028 Reset values: pc=RESET_PC, state=IDLE, instr_valid=0, imem_req=0, instr=32'h0000_0013 (nop), instr_pc=RESET_PC.
REQ-029 Reset asserted during REQ SHALL drop imem_req in the following cycle; any ack in the reset cycle SHALL be ignored.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN, when defined, SHALL add output misalign_err (1 bit, reset 0).
  - With the macro: a redirect with redirect_target[1:0]!=0 SHALL pulse misalign_err for one cycle (the cycle after the redirect) and load pc with {redirect_target[31:2],2'b00}.
  - Without the macro: the port SHALL be absent, and pc SHALL load redirect_target verbatim.

Verification
REQ-031 Reset release with RESET_PC=0, imem_ack tied high, rdata=32'h00500093 -> instr_valid at cycle 3; instr_pc=0, opcode=7'b0010011, pc_plus4=4.
REQ-032 stall=1 held 4 cycles in HOLD -> instr, instr_pc and instr_valid stable and imem_req=0 throughout; next fetch addr=0x4 after release.
REQ-033 redirect_valid with target 0x100 in the same cycle as imem_ack -> no instr_valid for the old word; next imem_addr=0x100.
REQ-034 pc=32'hFFFF_FFFC, ack -> instr_pc=32'hFFFF_FFFC, pc_plus4=0, next imem_addr=0.
REQ-035 rst asserted mid-REQ together with redirect to 0x200 -> pc=RESET_PC, state IDLE, instr_valid=0.
REQ-036 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> misalign_err=1 for one cycle, imem_addr=0x100.
